// File: rtl/cpu_pkg.sv
// Shared CPU definitions: condition-code encodings and flag bit positions
// for the {N,Z,C,V} flag register.
package cpu_pkg;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_HS = 4'b0010;
   localparam logic [3:0] COND_LO = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_flag_unit_cond_check.sv
// Combinational condition evaluator: decides whether an instruction's
// condition field passes against the architectural flags.
module cond_check
   import cpu_pkg::*;
(
   input  logic [3:0] Cond,
   input  logic [3:0] Flags,
   output logic       CondEx,
   output logic       illegal
);

   logic flagN;
   logic flagZ;
   logic flagC;
   logic flagV;

   assign flagN = Flags[FLAG_N];
   assign flagZ = Flags[FLAG_Z];
   assign flagC = Flags[FLAG_C];
   assign flagV = Flags[FLAG_V];

   assign illegal = (Cond == COND_NV);

   // The reserved encoding never executes; it is reported through illegal.
   always_comb begin
      CondEx = 1'b0;
      case (Cond)
         COND_EQ: CondEx = flagZ;
         COND_NE: CondEx = ~flagZ;
         COND_HS: CondEx = flagC;
         COND_LO: CondEx = ~flagC;
         COND_MI: CondEx = flagN;
         COND_PL: CondEx = ~flagN;
         COND_VS: CondEx = flagV;
         COND_VC: CondEx = ~flagV;
         COND_HI: CondEx = flagC & ~flagZ;
         COND_LS: CondEx = ~flagC | flagZ;
         COND_GE: CondEx = (flagN == flagV);
         COND_LT: CondEx = (flagN != flagV);
         COND_GT: CondEx = ~flagZ & (flagN == flagV);
         COND_LE: CondEx = flagZ | (flagN != flagV);
         COND_AL: CondEx = 1'b1;
         default: CondEx = 1'b0;
      endcase
   end

endmodule

// File: rtl/cond_flag_unit.sv
// Flag register and conditional-execution gate between the decoder/ALU and
// the register file / PC mux, with a saturating condition-fail counter.
module cond_flag_unit
   import cpu_pkg::*;
#(
   parameter int CNT_W    = 16,
   parameter bit REG_OUTS = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             flush,
   input  logic [3:0]       Cond,
   input  logic [3:0]       ALUFlags,
   input  logic [1:0]       FlagW,
   input  logic             PCS,
   input  logic             RegW,
   input  logic             MemW,
   input  logic             NoWrite,
   output logic             PCSrc,
   output logic             RegWrite,
   output logic             MemWrite,
   output logic             CondEx,
   output logic [3:0]       Flags,
   output logic             illegal_cond,
   output logic [CNT_W-1:0] fail_cnt
);

   logic validInstr;
   logic illegalNow;
   logic pcGate;
   logic regGate;
   logic memGate;

   cond_check uCondCheck (
      .Cond    (Cond),
      .Flags   (Flags),
      .CondEx  (CondEx),
      .illegal (illegalNow)
   );

   assign validInstr = en & ~flush;

   assign pcGate  = validInstr & CondEx & PCS;
   assign regGate = validInstr & CondEx & RegW & ~NoWrite;
   assign memGate = validInstr & CondEx & MemW;

   // N/Z and C/V halves load independently; the new values only become
   // visible to the following instruction.
   always_ff @(posedge clk) begin
      if (reset) begin
         Flags <= 4'b0000;
      end else if (validInstr && CondEx) begin
         if (FlagW[1]) begin
            Flags[FLAG_N] <= ALUFlags[FLAG_N];
            Flags[FLAG_Z] <= ALUFlags[FLAG_Z];
         end
         if (FlagW[0]) begin
            Flags[FLAG_C] <= ALUFlags[FLAG_C];
            Flags[FLAG_V] <= ALUFlags[FLAG_V];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         illegal_cond <= 1'b0;
      end else begin
         illegal_cond <= validInstr & illegalNow;
      end
   end

   // Counter sticks at all-ones so a long run of failures never looks small.
   always_ff @(posedge clk) begin
      if (reset) begin
         fail_cnt <= '0;
      end else if (validInstr && !CondEx && (fail_cnt != {CNT_W{1'b1}})) begin
         fail_cnt <= fail_cnt + CNT_W'(1);
      end
   end

   generate
      if (REG_OUTS) begin : gRegOuts
         logic pcReg;
         logic regReg;
         logic memReg;

         // Flush clears the captured enables even while the pipe is stalled.
         always_ff @(posedge clk) begin
            if (reset || flush) begin
               pcReg  <= 1'b0;
               regReg <= 1'b0;
               memReg <= 1'b0;
            end else if (en) begin
               pcReg  <= pcGate;
               regReg <= regGate;
               memReg <= memGate;
            end
         end

         assign PCSrc    = pcReg;
         assign RegWrite = regReg;
         assign MemWrite = memReg;
      end else begin : gCombOuts
         assign PCSrc    = pcGate;
         assign RegWrite = regGate;
         assign MemWrite = memGate;
      end
   endgenerate

endmodule
